// File: rtl/universal_shift_engine.sv
// rtl/universal_shift_engine.sv - multi-mode shift register with command handshake and shift-by-N sequencing
module universal_shift_engine #(
    parameter int WIDTH = 8,
    parameter int AMT_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [2:0]       cmd_op,
    input  logic [AMT_W-1:0] cmd_amt,
    input  logic [WIDTH-1:0] data_in,
    input  logic             serial_in,
    output logic [WIDTH-1:0] data_out,
    output logic             serial_out,
    output logic             busy,
    output logic             done
);

    localparam logic [2:0] OP_CLEAR = 3'd0;
    localparam logic [2:0] OP_LOAD  = 3'd1;
    localparam logic [2:0] OP_SHL   = 3'd2;
    localparam logic [2:0] OP_SHR   = 3'd3;
    localparam logic [2:0] OP_SRA   = 3'd4;
    localparam logic [2:0] OP_ROL   = 3'd5;
    localparam logic [2:0] OP_ROR   = 3'd6;
    localparam logic [2:0] OP_NOP   = 3'd7;

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t           state_q, state_d;
    logic [AMT_W-1:0] cnt;
    logic [2:0]       op_q;
    logic             dir;
    logic             accept;
    logic             cmd_is_shift;
    logic             start_multi;

    function automatic logic [WIDTH-1:0] step_fn(input logic [2:0] op,
                                                 input logic [WIDTH-1:0] d,
                                                 input logic sin);
        logic [WIDTH-1:0] r;
        r = d;
        case (op)
            OP_SHL:  r = {d[WIDTH-2:0], sin};
            OP_SHR:  r = {sin, d[WIDTH-1:1]};
            OP_SRA:  r = {d[WIDTH-1], d[WIDTH-1:1]};
            OP_ROL:  r = {d[WIDTH-2:0], d[WIDTH-1]};
            OP_ROR:  r = {d[0], d[WIDTH-1:1]};
            default: r = d;
        endcase
        return r;
    endfunction

    assign cmd_ready    = (state_q == IDLE);
    assign busy         = (state_q == SHIFT);
    assign serial_out   = dir ? data_out[0] : data_out[WIDTH-1];
    assign accept       = cmd_valid && cmd_ready;
    assign cmd_is_shift = (cmd_op != OP_CLEAR) && (cmd_op != OP_LOAD) && (cmd_op != OP_NOP);
    assign start_multi  = accept && cmd_is_shift && (cmd_amt != '0);

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start_multi) state_d = SHIFT;
            SHIFT:   if (cnt == AMT_W'(1)) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Single-cycle ops complete at the accept edge; shifts with amt>0 step once per edge in SHIFT.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            data_out <= '0;
            cnt      <= '0;
            op_q     <= '0;
            dir      <= 1'b0;
            done     <= 1'b0;
        end else begin
            done <= 1'b0;
            if (state_q == SHIFT) begin
                data_out <= step_fn(op_q, data_out, serial_in);
                cnt      <= cnt - AMT_W'(1);
                if (cnt == AMT_W'(1)) done <= 1'b1;
            end else if (accept) begin
                if (start_multi) begin
                    op_q <= cmd_op;
                    cnt  <= cmd_amt;
                    dir  <= !((cmd_op == OP_SHL) || (cmd_op == OP_ROL));
                end else begin
                    done <= 1'b1;
                    if (cmd_op == OP_CLEAR) data_out <= '0;
                    else if (cmd_op == OP_LOAD) data_out <= data_in;
                end
            end
        end
    end

endmodule

// File: tb/tb_universal_shift_engine.sv
// tb/tb_universal_shift_engine.sv - randomized model-checked bench for universal_shift_engine
module tb_universal_shift_engine;

    localparam int W = 8;
    localparam int A = 4;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         cmd_valid = 1'b0;
    logic         cmd_ready;
    logic [2:0]   cmd_op = 3'd7;
    logic [A-1:0] cmd_amt = '0;
    logic [W-1:0] data_in = '0;
    logic         serial_in = 1'b0;
    logic [W-1:0] data_out;
    logic         serial_out;
    logic         busy;
    logic         done;

    int n_vec = 0;
    int n_err = 0;
    bit checking = 1'b0;

    logic [W-1:0] m_data;
    int           m_rem;
    logic [2:0]   m_op;
    logic         m_dir;
    logic         m_done;

    universal_shift_engine #(.WIDTH(W), .AMT_W(A)) dut (
        .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_amt(cmd_amt), .data_in(data_in), .serial_in(serial_in),
        .data_out(data_out), .serial_out(serial_out), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [W-1:0] mstep(input logic [2:0] op, input logic [W-1:0] d, input logic sin);
        case (op)
            3'd2:    return (d << 1) | W'(sin);
            3'd3:    return (d >> 1) | (W'(sin) << (W - 1));
            3'd4:    return (d >> 1) | (d & (W'(1) << (W - 1)));
            3'd5:    return (d << 1) | (d >> (W - 1));
            3'd6:    return (d >> 1) | (d << (W - 1));
            default: return d;
        endcase
    endfunction

    task automatic model_reset();
        m_data = '0; m_rem = 0; m_op = '0; m_dir = 1'b0; m_done = 1'b0;
    endtask

    // Model advance for one rising edge, given the inputs presented to it.
    task automatic model_edge();
        m_done = 1'b0;
        if (m_rem > 0) begin
            m_data = mstep(m_op, m_data, serial_in);
            m_rem--;
            if (m_rem == 0) m_done = 1'b1;
        end else if (cmd_valid) begin
            if (cmd_op == 3'd0)      begin m_data = '0; m_done = 1'b1; end
            else if (cmd_op == 3'd1) begin m_data = data_in; m_done = 1'b1; end
            else if (cmd_op == 3'd7 || cmd_amt == 0) m_done = 1'b1;
            else begin
                m_op  = cmd_op;
                m_rem = int'(cmd_amt);
                m_dir = !(cmd_op == 3'd2 || cmd_op == 3'd5);
            end
        end
    endtask

    always @(negedge clk) begin
        if (checking && !reset) begin
            chk("data_out",   32'(data_out),   32'(m_data));
            chk("cmd_ready",  32'(cmd_ready),  32'(m_rem == 0));
            chk("busy",       32'(busy),       32'(m_rem > 0));
            chk("done",       32'(done),       32'(m_done));
            chk("serial_out", 32'(serial_out), 32'(m_dir ? m_data[0] : m_data[W-1]));
        end
    end

    task automatic tick(input logic v, input logic [2:0] op, input int amt,
                        input logic [W-1:0] din, input logic sin);
        @(negedge clk);
        cmd_valid = v; cmd_op = op; cmd_amt = A'(amt); data_in = din; serial_in = sin;
        @(posedge clk);
        if (!reset) model_edge();
    endtask

    task automatic rst_pulse();
        #2 reset = 1'b1;
        model_reset();
        #1;
        chk("rst_data", 32'(data_out), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_done", 32'(done), 32'h0);
        chk("rst_ready", 32'(cmd_ready), 32'h1);
        @(posedge clk);
        #2 reset = 1'b0;
    endtask

    initial begin
        model_reset();
        repeat (3) @(posedge clk);
        #2 reset = 1'b0;
        checking = 1'b1;
        #1;
        chk("init_data", 32'(data_out), 32'h0);
        chk("init_ready", 32'(cmd_ready), 32'h1);
        chk("init_busy", 32'(busy), 32'h0);
        chk("init_done", 32'(done), 32'h0);
        chk("init_sout", 32'(serial_out), 32'h0);

        tick(1, 3'd1, 0, 8'hA5, 0); #1;
        chk("load_a5", 32'(data_out), 32'hA5);
        chk("load_done", 32'(done), 32'h1);
        tick(1, 3'd1, 0, 8'h3C, 0); #1;
        chk("load_3c_b2b", 32'(data_out), 32'h3C);
        tick(0, 3'd7, 0, 8'h00, 0); #1;
        chk("done_cleared", 32'(done), 32'h0);

        tick(1, 3'd1, 0, 8'h81, 0);
        tick(1, 3'd2, 3, 8'h00, 1); #1;
        chk("shl_t0_data", 32'(data_out), 32'h81);
        chk("shl_t0_busy", 32'(busy), 32'h1);
        tick(0, 3'd7, 0, 8'h00, 1); #1; chk("shl_s1", 32'(data_out), 32'h03);
        tick(0, 3'd7, 0, 8'h00, 1); #1; chk("shl_s2", 32'(data_out), 32'h07);
        tick(0, 3'd7, 0, 8'h00, 1); #1; chk("shl_s3", 32'(data_out), 32'h0F);
        chk("shl_done", 32'(done), 32'h1);
        chk("shl_sout", 32'(serial_out), 32'h0);

        tick(1, 3'd1, 0, 8'h90, 0);
        tick(1, 3'd4, 2, 8'h00, 0);
        tick(0, 3'd7, 0, 8'h00, 0); #1; chk("sra_s1", 32'(data_out), 32'hC8);
        tick(0, 3'd7, 0, 8'h00, 0); #1; chk("sra_s2", 32'(data_out), 32'hE4);
        chk("sra_sout", 32'(serial_out), 32'h0);

        tick(1, 3'd1, 0, 8'h01, 0);
        tick(1, 3'd6, 8, 8'h00, 0);
        for (int i = 0; i < 8; i++) tick(i == 2, 3'd1, 0, 8'hFF, 0);
        #1;
        chk("ror8_data", 32'(data_out), 32'h01);
        chk("ror8_done", 32'(done), 32'h1);

        tick(1, 3'd1, 0, 8'h55, 0);
        tick(1, 3'd3, 0, 8'h00, 1); #1;
        chk("shr0_data", 32'(data_out), 32'h55);
        chk("shr0_busy", 32'(busy), 32'h0);
        chk("shr0_done", 32'(done), 32'h1);

        tick(1, 3'd2, 5, 8'h00, 0);
        tick(0, 3'd7, 0, 8'h00, 0);
        tick(0, 3'd7, 0, 8'h00, 0); #1;
        chk("shl5_s2", 32'(data_out), 32'h54);
        rst_pulse();
        tick(0, 3'd7, 0, 8'h00, 0); #1;
        chk("abort_no_done", 32'(done), 32'h0);

        for (int i = 0; i < 3000; i++) begin
            tick($urandom_range(0, 9) < 7, 3'($urandom_range(0, 7)),
                 ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(0, 15)),
                 8'($urandom), 1'($urandom));
            if ($urandom_range(0, 249) == 0) rst_pulse();
        end

        @(negedge clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
